// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and helpers for the configurable UART receiver:
//               FSM state encoding, data-bit configuration codes and the
//               mapping from configuration code to data-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } uart_rx_state_e;

  // Data-bit configuration codes
  localparam logic [1:0] CFG_BITS_5 = 2'b00;
  localparam logic [1:0] CFG_BITS_6 = 2'b01;
  localparam logic [1:0] CFG_BITS_7 = 2'b10;
  localparam logic [1:0] CFG_BITS_8 = 2'b11;

  // Number of data bits in a frame for a given configuration code
  function automatic logic [3:0] cfg_bits_to_count(input logic [1:0] cfg_bits);
    case (cfg_bits)
      CFG_BITS_5: return 4'd5;
      CFG_BITS_6: return 4'd6;
      CFG_BITS_7: return 4'd7;
      default:    return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_buf
// Description : Synchronous receive FIFO with valid/ready pop, push with
//               overrun indication and occupancy count. Head data reads as
//               zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_buf #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  output logic                          overrun_o,
  input  logic                          pop_ready_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              w_full, w_empty, w_pop, w_push_ok;

  assign w_full    = (count_q == FULL_CNT);
  assign w_empty   = (count_q == '0);
  assign w_pop     = pop_ready_i & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_ok = push_i & (~w_full | w_pop);
  assign overrun_o = push_i & w_full & ~w_pop;

  assign valid_o = ~w_empty;
  assign data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy follows the accepted push/pop pair
  always_comb begin
    count_d = count_q;
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset needed since the head is masked while empty
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Runtime-configurable UART receiver (5-8 data bits, optional
//               parity, 1 or 2 stop bits, programmable baud divisor) feeding
//               a receive FIFO with ready/valid output and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic [1:0]                  cfg_bits_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_parity_odd_i,
  input  logic                        cfg_stop2_i,
  input  logic                        rx_i,
  output logic [DATA_W-1:0]           rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] rx_count_o,
  output logic                        parity_err_o,
  output logic                        frame_err_o,
  output logic                        overrun_err_o,
  output logic                        busy_o
);

  localparam int               OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0]  OS_FULL = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  uart_rx_state_e state_q, state_d;

  logic             sync1_q, sync2_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q, div_lat_q;
  logic [OS_W-1:0]  os_cnt_q, w_os_target;
  logic [1:0]       bits_q;
  logic             par_en_q, par_odd_q, stop2_q, par_err_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             w_rx, w_start, w_tick, w_active, w_sample, w_last_bit;
  logic             w_push, w_frame_err, w_parity_err;
  logic [DATA_W-1:0] w_push_data;

  assign w_rx       = sync2_q;
  assign w_start    = (state_q == ST_IDLE) & rx_prev_q & ~sync2_q;
  assign w_tick     = (div_cnt_q == '0);
  assign w_active   = (state_q != ST_IDLE) && (state_q != ST_BREAK);
  assign w_os_target = (state_q == ST_START) ? OS_HALF : OS_FULL;
  assign w_sample   = w_tick & w_active & (os_cnt_q == w_os_target);
  assign w_last_bit = ({1'b0, bit_idx_q} == (cfg_bits_to_count(bits_q) - 4'd1));

  assign busy_o       = (state_q != ST_IDLE);
  assign frame_err_o  = w_frame_err;
  assign parity_err_o = w_parity_err;

  // Two-flop synchroniser plus a history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Free-running baud tick divider, realigned to the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      div_lat_q <= '0;
    end else if (w_start) begin
      div_cnt_q <= cfg_div_i;
      div_lat_q <= cfg_div_i;
    end else if (w_tick) begin
      // While idle track the live divisor; in a frame use the latched one
      div_cnt_q <= (state_q == ST_IDLE) ? cfg_div_i : div_lat_q;
    end else begin
      div_cnt_q <= div_cnt_q - DIV_ONE;
    end
  end

  // Oversample tick counter locating the mid-bit sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q <= '0;
    end else if (w_start) begin
      os_cnt_q <= '0;
    end else if (w_tick && w_active) begin
      os_cnt_q <= (os_cnt_q == w_os_target) ? '0 : os_cnt_q + OS_ONE;
    end
  end

  // Frame configuration latch, data shift-in and parity evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q    <= CFG_BITS_5;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
    end else if (w_start) begin
      bits_q    <= cfg_bits_i;
      par_en_q  <= cfg_parity_en_i;
      par_odd_q <= cfg_parity_odd_i;
      stop2_q   <= cfg_stop2_i;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
    end else if (w_sample) begin
      case (state_q)
        ST_DATA: begin
          shreg_q[bit_idx_q] <= w_rx;
          bit_idx_q          <= bit_idx_q + 3'd1;
        end
        // Unused upper data bits are zero, so an 8-bit reduction is exact
        ST_PARITY: par_err_q <= (^shreg_q) ^ w_rx ^ par_odd_q;
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and frame-completion outcome
  always_comb begin
    state_d      = state_q;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;
    case (state_q)
      ST_IDLE: if (w_start) state_d = ST_START;
      ST_START: begin
        if (w_sample) state_d = w_rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && w_last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (w_sample) state_d = ST_STOP1;
      ST_STOP1, ST_STOP2: begin
        if (w_sample) begin
          if (!w_rx) begin
            w_frame_err = 1'b1;
            state_d     = ST_BREAK;
          end else if ((state_q == ST_STOP1) && stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            w_parity_err = par_err_q;
            w_push       = ~par_err_q;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_BREAK: if (w_rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Zero-extend the received character to the output width
  generate
    if (DATA_W > 8) begin : g_data_ext
      assign w_push_data = {{(DATA_W-8){1'b0}}, shreg_q};
    end else begin : g_data_fit
      assign w_push_data = shreg_q[DATA_W-1:0];
    end
  endgenerate

  uart_rx_fifo_buf #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .overrun_o   (overrun_err_o),
    .pop_ready_i (rx_ready_i),
    .data_o      (rx_data_o),
    .valid_o     (rx_valid_o),
    .count_o     (rx_count_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Received bytes are
//               checked against a scoreboard queue filled as frames are sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_bits;
  logic        cfg_par_en, cfg_par_odd, cfg_stop2;
  logic        rx_i, rx_ready_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic [4:0]  rx_count_o;
  logic        parity_err_o, frame_err_o, overrun_err_o, busy_o;

  int checks = 0;
  int errors = 0;
  int n_par = 0, n_frm = 0, n_ovr = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_div_i        (cfg_div),
    .cfg_bits_i       (cfg_bits),
    .cfg_parity_en_i  (cfg_par_en),
    .cfg_parity_odd_i (cfg_par_odd),
    .cfg_stop2_i      (cfg_stop2),
    .rx_i             (rx_i),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready_i),
    .rx_count_o       (rx_count_o),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_err_o    (overrun_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  // Output monitor: compares every pop against the scoreboard, counts pulses
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (parity_err_o)  n_par++;
      if (frame_err_o)   n_frm++;
      if (overrun_err_o) n_ovr++;
      if (rx_valid_o && rx_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %02h, expected no data", rx_data_o);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data_o !== exp) begin
            errors++;
            $display("FAIL pop_data: got %02h, expected %02h", rx_data_o, exp);
          end
        end
      end
    end
  end

  function automatic logic good_parity(input logic [7:0] d, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < nbits; i++) p = p ^ d[i];
    return p;
  endfunction

  // Serialise one frame on rx_i; second stop bit value is selectable
  task automatic uart_send(input logic [7:0] d, input int nbits, input bit pen,
                           input bit pbit, input bit use2, input bit s2, input int div);
    int bc;
    bc = (div + 1) * 16;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      repeat (bc) @(negedge clk);
    end
    if (pen) begin
      rx_i = pbit;
      repeat (bc) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (bc) @(negedge clk);
    if (use2) begin
      rx_i = s2;
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_i = 1'b1; rx_ready_i = 1'b0;
    cfg_div = 16'd0; cfg_bits = 2'b11; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", rx_valid_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", rx_data_o); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", rx_count_o); end
    checks++; if ({busy_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 0000", {busy_o, parity_err_o, frame_err_o, overrun_err_o}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy_o); end
  endtask

  task automatic test_8n1;
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    exp_q.push_back(8'hA5);
    uart_send(8'hA5, 8, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL 8n1_head: got %02h, expected a5", rx_data_o); end
    checks++; if (rx_count_o !== 5'd1) begin errors++; $display("FAIL 8n1_count: got %0d, expected 1", rx_count_o); end
    checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL 8n1_valid: got %b, expected 1", rx_valid_o); end
    checks++; if ((n_par - p0) + (n_frm - f0) != 0) begin errors++; $display("FAIL 8n1_errs: got %0d pulses, expected 0", (n_par - p0) + (n_frm - f0)); end
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL 8n1_drain_count: got %0d, expected 0", rx_count_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL 8n1_drain_valid: got %b, expected 0", rx_valid_o); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL 8n1_sb: got %0d left, expected 0", exp_q.size()); end
    rx_ready_i = 1'b0;
  endtask

  task automatic test_parity;
    int p0;
    logic pg;
    p0 = n_par;
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0; rx_ready_i = 1'b1;
    pg = good_parity(8'h3C, 8, 1'b0);
    uart_send(8'h3C, 8, 1, ~pg, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (n_par - p0 != 1) begin errors++; $display("FAIL par_pulse: got %0d, expected 1", n_par - p0); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL par_count: got %0d, expected 0", rx_count_o); end
    exp_q.push_back(8'h3C);
    uart_send(8'h3C, 8, 1, pg, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL par_good_sb: got %0d left, expected 0", exp_q.size()); end
    checks++; if (n_par - p0 != 1) begin errors++; $display("FAIL par_good_pulse: got %0d, expected 1", n_par - p0); end
    cfg_par_en = 1'b0; rx_ready_i = 1'b0;
  endtask

  task automatic test_7bit_stop2;
    int f0;
    f0 = n_frm;
    cfg_div = 16'd3; cfg_bits = 2'b10; cfg_stop2 = 1'b1;
    exp_q.push_back(8'h7F);
    uart_send(8'h7F, 7, 0, 0, 1, 1, 3);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rx_data_o !== 8'h7F) begin errors++; $display("FAIL s2_head: got %02h, expected 7f", rx_data_o); end
    checks++; if (rx_count_o !== 5'd1) begin errors++; $display("FAIL s2_count: got %0d, expected 1", rx_count_o); end
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready_i = 1'b0;
    uart_send(8'h7F, 7, 0, 0, 1, 0, 3);
    repeat (128) @(negedge clk);
    #1;
    checks++; if (n_frm - f0 != 1) begin errors++; $display("FAIL s2_frame_pulse: got %0d, expected 1", n_frm - f0); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL s2_break_busy: got %b, expected 1", busy_o); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL s2_break_count: got %0d, expected 0", rx_count_o); end
    rx_i = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL s2_release_busy: got %b, expected 0", busy_o); end
    checks++; if (n_frm - f0 != 1) begin errors++; $display("FAIL s2_no_restart: got %0d frame pulses, expected 1", n_frm - f0); end
    cfg_div = 16'd0; cfg_bits = 2'b11; cfg_stop2 = 1'b0;
  endtask

  task automatic test_overrun;
    int o0, o16;
    o0 = n_ovr;
    rx_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      if (i == 16) o16 = n_ovr;
      uart_send(8'(i), 8, 0, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o16 - o0 != 0) begin errors++; $display("FAIL ovr_early: got %0d pulses before byte 17, expected 0", o16 - o0); end
    checks++; if (n_ovr - o16 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d, expected 1", n_ovr - o16); end
    checks++; if (rx_count_o !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d, expected 16", rx_count_o); end
    rx_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_drain_sb: got %0d left, expected 0", exp_q.size()); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL ovr_drain_count: got %0d, expected 0", rx_count_o); end
    rx_ready_i = 1'b0;
  endtask

  task automatic test_glitch;
    int e0;
    e0 = n_par + n_frm + n_ovr;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy %b, expected 1", busy_o); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b, expected 0", busy_o); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL glitch_count: got %0d, expected 0", rx_count_o); end
    checks++; if (n_par + n_frm + n_ovr != e0) begin errors++; $display("FAIL glitch_errs: got %0d pulses, expected 0", n_par + n_frm + n_ovr - e0); end
  endtask

  task automatic test_reset_mid;
    int e0;
    logic [7:0] d;
    e0 = n_par + n_frm + n_ovr;
    rx_ready_i = 1'b0;
    uart_send(8'h11, 8, 0, 0, 0, 0, 0);
    uart_send(8'h22, 8, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rx_count_o !== 5'd2) begin errors++; $display("FAIL rmid_pre_count: got %0d, expected 2", rx_count_o); end
    d = 8'h5A;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_i = d[i];
      repeat (16) @(negedge clk);
    end
    rx_i = d[3];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o} !== 5'b00000) begin
      errors++; $display("FAIL rmid_flags: got %b, expected 00000", {rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o}); end
    checks++; if (rx_count_o !== 5'd0) begin errors++; $display("FAIL rmid_count: got %0d, expected 0", rx_count_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rmid_data: got %02h, expected 00", rx_data_o); end
    rx_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_ready_i = 1'b1;
    exp_q.push_back(8'h5A);
    uart_send(8'h5A, 8, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_after_sb: got %0d left, expected 0", exp_q.size()); end
    checks++; if (n_par + n_frm + n_ovr != e0) begin errors++; $display("FAIL rmid_errs: got %0d pulses, expected 0", n_par + n_frm + n_ovr - e0); end
    rx_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7bit_stop2();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
